// File: rtl/frame_tile_sched_if.sv
// Handshake bundle between the tile scheduler, the frame memory read port and the 3x3 filter core.
// The master side is the scheduler; the slave side is the memory/datapath environment.
interface frame_tile_sched_if;
    logic       start;
    logic       busy;
    logic       mem_req;
    logic [8:0] mem_row;
    logic [9:0] mem_col;
    logic       mem_gnt;
    logic [1:0] ld_sel;
    logic       dp_start;
    logic [5:0] dp_width;
    logic       dp_done;
    logic [8:0] out_row;
    logic [9:0] out_col;
    logic       frame_done;

    modport master (
        input  start, mem_gnt, dp_done,
        output busy, mem_req, mem_row, mem_col, ld_sel,
               dp_start, dp_width, out_row, out_col, frame_done
    );

    modport slave (
        output start, mem_gnt, dp_done,
        input  busy, mem_req, mem_row, mem_col, ld_sel,
               dp_start, dp_width, out_row, out_col, frame_done
    );
endinterface

// File: rtl/frame_tile_sched.sv
// Walks the padded frame in TILE_W-wide output tiles: three row-segment reads per tile,
// then a datapath launch and a wait for completion before moving to the next tile.
module frame_tile_sched #(
    parameter int IMG_W  = 638,
    parameter int IMG_H  = 482,
    parameter int TILE_W = 36
) (
    input  logic                      clk,
    input  logic                      rst,
    frame_tile_sched_if.master        bus
);
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int NT    = (OUT_W + TILE_W - 1) / TILE_W;
    localparam int TC_W  = $clog2(NT);
    localparam int RC_W  = $clog2(OUT_H);

    localparam logic [TC_W-1:0] TC_LAST = TC_W'(NT - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(OUT_H - 1);
    localparam logic [5:0]      W_FULL  = 6'(TILE_W);
    localparam logic [5:0]      W_LAST  = 6'(OUT_W - (NT - 1) * TILE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FIRE,
        S_WAIT,
        S_ADV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TC_W-1:0] tc_q, tc_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [1:0]      fc_q, fc_d;
    logic [5:0]      dp_width_q, dp_width_d;

    logic last_tile;
    logic last_row;

    assign last_tile = (tc_q == TC_LAST);
    assign last_row  = (rc_q == RC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tc_q       <= '0;
            rc_q       <= '0;
            fc_q       <= '0;
            dp_width_q <= '0;
        end else begin
            state_q    <= state_d;
            tc_q       <= tc_d;
            rc_q       <= rc_d;
            fc_q       <= fc_d;
            dp_width_q <= dp_width_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tc_d       = tc_q;
        rc_d       = rc_q;
        fc_d       = fc_q;
        dp_width_d = dp_width_q;
        case (state_q)
            S_IDLE: begin
                dp_width_d = '0;
                if (bus.start) begin
                    tc_d    = '0;
                    rc_d    = '0;
                    fc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                dp_width_d = '0;
                if (bus.mem_gnt) begin
                    if (fc_q == 2'd2) begin
                        fc_d       = '0;
                        dp_width_d = last_tile ? W_LAST : W_FULL;
                        state_d    = S_FIRE;
                    end else begin
                        fc_d = fc_q + 2'd1;
                    end
                end
            end
            S_FIRE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.dp_done) state_d = S_ADV;
            end
            S_ADV: begin
                // Counters are cleared on the final tile so out_row never reads past the last row.
                if (last_tile && last_row) begin
                    tc_d    = '0;
                    rc_d    = '0;
                    state_d = S_DONE;
                end else if (!last_tile) begin
                    tc_d    = tc_q + TC_W'(1);
                    state_d = S_FETCH;
                end else begin
                    tc_d    = '0;
                    rc_d    = rc_q + RC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                dp_width_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_row    = '0;
        bus.mem_col    = '0;
        bus.ld_sel     = '0;
        bus.dp_start   = 1'b0;
        bus.dp_width   = dp_width_q;
        bus.out_row    = '0;
        bus.out_col    = '0;
        bus.frame_done = 1'b0;
        if (state_q != S_IDLE) begin
            bus.busy    = 1'b1;
            bus.out_row = 9'(rc_q);
            bus.out_col = 10'(tc_q * TILE_W);
        end
        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.mem_row = 9'(rc_q) + 9'(fc_q);
                bus.mem_col = 10'(tc_q * TILE_W);
                bus.ld_sel  = fc_q;
            end
            S_FIRE:  bus.dp_start   = 1'b1;
            S_DONE:  bus.frame_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_frame_tile_sched.sv
// Randomized bench for frame_tile_sched: fixed-latency scenarios plus a full frame checked
// against a request/width list generated from the tiling rules.
module tb_frame_tile_sched;
    localparam int NT     = 18;
    localparam int OUT_H  = 480;
    localparam int TILE_W = 36;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    frame_tile_sched_if bus ();

    frame_tile_sched #(.IMG_W(638), .IMG_H(482), .TILE_W(TILE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic [49:0] outs;
    assign outs = {bus.busy, bus.mem_req, bus.mem_row, bus.mem_col, bus.ld_sel, bus.dp_start,
                   bus.dp_width, bus.out_row, bus.out_col, bus.frame_done};

    typedef struct {
        int row;
        int col;
        int sel;
        int orow;
    } req_t;

    req_t exp_q[$];
    int   w_q[$];

    // Reference: every tile of every output row needs rows r..r+2 at column t*TILE_W.
    function automatic void build_frame_model();
        req_t r;
        exp_q.delete();
        w_q.delete();
        for (int row = 0; row < OUT_H; row++) begin
            for (int t = 0; t < NT; t++) begin
                for (int f = 0; f < 3; f++) begin
                    r.row  = row + f;
                    r.col  = t * TILE_W;
                    r.sel  = f;
                    r.orow = row;
                    exp_q.push_back(r);
                end
                w_q.push_back((t == NT - 1) ? (636 - (NT - 1) * TILE_W) : TILE_W);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 0; bus.mem_gnt = 0; bus.dp_done = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.start   = 1'($urandom);
            bus.mem_gnt = 1'($urandom);
            bus.dp_done = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        bus.start = 0; bus.mem_gnt = 0; bus.dp_done = 0;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick();
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h expected 0", outs);
        end
    endtask

    task automatic test_first_tile();
        do_reset();
        bus.start = 1; bus.mem_gnt = 1;
        for (int c = 1; c <= 7; c++) begin
            logic exp_req;
            int   exp_row, exp_col, exp_sel;
            tick();
            exp_req = (c <= 3) || (c == 7);
            exp_row = (c <= 3) ? c - 1 : 0;
            exp_col = (c == 7) ? 36 : 0;
            exp_sel = (c <= 3) ? c - 1 : 0;
            checks++;
            if (bus.busy !== 1'b1 || bus.mem_req !== exp_req || bus.dp_start !== (c == 4)) begin
                errors++;
                $display("FAIL first_ctrl c%0d: busy=%b req=%b dps=%b expected 1 %b %b",
                         c, bus.busy, bus.mem_req, bus.dp_start, exp_req, (c == 4));
            end
            if (exp_req) begin
                checks++;
                if (bus.mem_row !== 9'(exp_row) || bus.mem_col !== 10'(exp_col) || bus.ld_sel !== 2'(exp_sel)) begin
                    errors++;
                    $display("FAIL first_addr c%0d: row=%0d col=%0d sel=%0d expected %0d %0d %0d",
                             c, bus.mem_row, bus.mem_col, bus.ld_sel, exp_row, exp_col, exp_sel);
                end
            end
            if (c == 4 || c == 7) begin
                checks++;
                if (bus.out_col !== 10'(exp_col) || (c == 4 && bus.dp_width !== 6'd36)) begin
                    errors++;
                    $display("FAIL first_tile c%0d: out_col=%0d width=%0d expected %0d 36",
                             c, bus.out_col, bus.dp_width, exp_col);
                end
            end
            bus.start   = 0;
            bus.dp_done = (c == 5);
        end
        do_reset();
    endtask

    task automatic test_grant_stall();
        do_reset();
        bus.start = 1; bus.mem_gnt = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 0;
            if (c <= 7) begin
                int er, es;
                er = (c == 1) ? 0 : (c == 7) ? 2 : 1;
                es = er;
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_row !== 9'(er) || bus.ld_sel !== 2'(es) || bus.dp_start !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold c%0d: req=%b row=%0d sel=%0d dps=%b expected 1 %0d %0d 0",
                             c, bus.mem_req, bus.mem_row, bus.ld_sel, bus.dp_start, er, es);
                end
            end else begin
                checks++;
                if (bus.dp_start !== 1'b1 || bus.mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_fire: dps=%b req=%b expected 1 0", bus.dp_start, bus.mem_req);
                end
            end
            bus.mem_gnt = !(c >= 2 && c <= 5);
        end
        do_reset();
    endtask

    task automatic test_row_wrap();
        int phase = 0;
        do_reset();
        bus.start = 1; bus.mem_gnt = 1; bus.dp_done = 1;
        for (int c = 0; c < 400 && phase < 3; c++) begin
            tick();
            bus.start = 0;
            if (phase == 0 && bus.mem_req && bus.mem_col == 10'd612) begin
                checks++;
                if (bus.mem_row !== 9'd0 || bus.out_col !== 10'd612 || bus.out_row !== 9'd0) begin
                    errors++;
                    $display("FAIL wrap_last_req: row=%0d out_col=%0d out_row=%0d expected 0 612 0",
                             bus.mem_row, bus.out_col, bus.out_row);
                end
                phase = 1;
            end else if (phase == 1 && bus.dp_start) begin
                checks++;
                if (bus.dp_width !== 6'd24) begin
                    errors++;
                    $display("FAIL wrap_width: got %0d expected 24", bus.dp_width);
                end
                phase = 2;
            end else if (phase == 2 && bus.mem_req) begin
                checks++;
                if (bus.mem_row !== 9'd1 || bus.mem_col !== 10'd0 || bus.out_row !== 9'd1 || bus.ld_sel !== 2'd0) begin
                    errors++;
                    $display("FAIL wrap_next_row: row=%0d col=%0d out_row=%0d sel=%0d expected 1 0 1 0",
                             bus.mem_row, bus.mem_col, bus.out_row, bus.ld_sel);
                end
                phase = 3;
            end
        end
        if (phase != 3) begin
            checks++;
            errors++;
            $display("FAIL wrap_timeout: reached phase %0d expected 3", phase);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int grants = 0, starts = 0, dones = 0;
        int last_row = -1, last_col = -1;
        bit finished = 0;
        build_frame_model();
        do_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int c = 0; c < 70000 && !finished && errors < 20; c++) begin
            if (bus.frame_done) begin
                dones++;
                checks++;
                if (bus.busy !== 1'b1 || exp_q.size() != 0 || w_q.size() != 0) begin
                    errors++;
                    $display("FAIL frame_done_early: busy=%b reqs_left=%0d tiles_left=%0d expected 1 0 0",
                             bus.busy, exp_q.size(), w_q.size());
                end
                // A start in the DONE cycle must not relaunch the frame.
                bus.start = 1; bus.mem_gnt = 1; bus.dp_done = 0;
                tick();
                bus.start = 0;
                checks++;
                if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL after_done: busy=%b req=%b fd=%b expected 0 0 0",
                             bus.busy, bus.mem_req, bus.frame_done);
                end
                tick();
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_start_ignored: busy=%b expected 0", bus.busy);
                end
                finished = 1;
            end else begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_busy cycle %0d: busy=%b expected 1", c, bus.busy);
                end
                bus.mem_gnt = ($urandom_range(0, 15) != 0);
                bus.dp_done = ($urandom_range(0, 7) != 0);
                bus.start   = (bus.out_row < 9'd479) && ($urandom_range(0, 31) == 0);
                if (bus.mem_req && bus.mem_gnt) begin
                    grants++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_extra_req: row=%0d col=%0d expected none", bus.mem_row, bus.mem_col);
                    end else begin
                        req_t e;
                        e = exp_q.pop_front();
                        if (bus.mem_row !== 9'(e.row) || bus.mem_col !== 10'(e.col) || bus.ld_sel !== 2'(e.sel) ||
                            bus.out_row !== 9'(e.orow) || bus.out_col !== 10'(e.col)) begin
                            errors++;
                            $display("FAIL frame_req %0d: row=%0d col=%0d sel=%0d orow=%0d ocol=%0d expected %0d %0d %0d %0d %0d",
                                     grants, bus.mem_row, bus.mem_col, bus.ld_sel, bus.out_row, bus.out_col,
                                     e.row, e.col, e.sel, e.orow, e.col);
                        end
                    end
                    last_row = int'(bus.mem_row);
                    last_col = int'(bus.mem_col);
                end
                if (bus.dp_start) begin
                    starts++;
                    checks++;
                    if (w_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_extra_fire: width=%0d expected none", bus.dp_width);
                    end else begin
                        int ew;
                        ew = w_q.pop_front();
                        if (bus.dp_width !== 6'(ew)) begin
                            errors++;
                            $display("FAIL frame_width tile %0d: got %0d expected %0d", starts, bus.dp_width, ew);
                        end
                    end
                end
                tick();
            end
        end
        bus.start = 0; bus.mem_gnt = 0; bus.dp_done = 0;
        checks++;
        if (!finished || dones != 1 || starts != NT * OUT_H || grants != 3 * NT * OUT_H) begin
            errors++;
            $display("FAIL frame_totals: finished=%0d done=%0d fires=%0d grants=%0d expected 1 1 %0d %0d",
                     finished, dones, starts, grants, NT * OUT_H, 3 * NT * OUT_H);
        end
        checks++;
        if (last_row != 481 || last_col != 612) begin
            errors++;
            $display("FAIL frame_last_req: row=%0d col=%0d expected 481 612", last_row, last_col);
        end
    endtask

    task automatic test_reset_midframe();
        bit hit = 0, saw_done = 0;
        do_reset();
        bus.start = 1; bus.mem_gnt = 1; bus.dp_done = 1;
        for (int c = 0; c < 3000 && !hit; c++) begin
            tick();
            bus.start = 0;
            if (bus.frame_done) saw_done = 1;
            if (bus.mem_req && bus.out_row == 9'd5 && bus.ld_sel == 2'd1) hit = 1;
        end
        checks++;
        if (!hit || saw_done) begin
            errors++;
            $display("FAIL midframe_reach: reached=%0d frame_done=%0d expected 1 0", hit, saw_done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_gnt = 0; bus.dp_done = 0;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got %h expected 0", outs);
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_row !== 9'd0 || bus.mem_col !== 10'd0 ||
            bus.ld_sel !== 2'd0 || bus.out_row !== 9'd0) begin
            errors++;
            $display("FAIL midframe_restart: busy=%b req=%b row=%0d col=%0d sel=%0d orow=%0d expected 1 1 0 0 0 0",
                     bus.busy, bus.mem_req, bus.mem_row, bus.mem_col, bus.ld_sel, bus.out_row);
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.mem_gnt = 0; bus.dp_done = 0;
        test_reset();
        test_first_tile();
        test_grant_stall();
        test_row_wrap();
        test_reset_midframe();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_tile_sched.md
# frame_tile_sched

Scheduler that sequences the 3x3 filter datapath over the padded frame buffer (638x482 pixels, 8 bit, 1-pixel border around a 636x480 image). For every output row it walks the row in 36-pixel output tiles. For each tile it issues three row-segment reads to the frame memory (rows r, r+1, r+2) and routes each to one of the datapath line registers via `ld_sel`. It then fires the datapath and waits for its completion before advancing. It sits between the frame memory port and the filter core inside `top`.

## Interface
- `IMG_W`, 638, padded frame width in pixels
- `IMG_H`, 482, padded frame height in pixels
- `TILE_W`, 36, output pixels per tile; each read segment covers `TILE_W`+2 input pixels

- `clk` in 1: rising-edge clock, the only clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a frame; sampled only in IDLE
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle
- `mem_req` out 1: read request to frame memory
- `mem_row` out 9: padded row address of the request
- `mem_col` out 10: first padded column of the segment, equal to tile index x `TILE_W`
- `mem_gnt` in 1: memory accepts the current request on a cycle where `mem_req` && `mem_gnt`
- `ld_sel` out 2: line register (0,1,2) that the accepted read fills; valid while `mem_req` is high
- `dp_start` out 1: one-cycle pulse that launches the datapath on the loaded tile
- `dp_width` out 6: valid output pixels in the tile, 36 or 24; held from FIRE until the next FETCH
- `dp_done` in 1: datapath finished the tile
- `out_row` out 9: output image row of the current tile (0..479)
- `out_col` out 10: output image column of the current tile (0, 36, …, 612)
- `frame_done` out 1: one-cycle pulse after the last tile's `dp_done`

## Operation
- Derived constants:
  - OUT_W = `IMG_W`-2 = 636
  - OUT_H = `IMG_H`-2 = 480
  - tiles per row NT = ceil(OUT_W/`TILE_W`) = 18
  - last tile width = OUT_W-(NT-1)x`TILE_W` = 24
  - total tiles = 8640
- Counters:
  - tile counter `tc` (0..NT-1)
  - row counter `rc` (0..OUT_H-1)
  - fetch counter `fc` (0..2)
- States are IDLE, FETCH, FIRE, WAIT, ADV and DONE.
- IDLE: all outputs 0.
  - On `start`=1, clear `tc`, `rc` and `fc`, then go to FETCH.
- FETCH: drive the request from the current counters.
  - `mem_req`=1, `mem_row`=`rc`+`fc`, `mem_col`=`tc`x`TILE_W`, `ld_sel`=`fc`.
  - On grant with `fc`<2: increment `fc`, stay in FETCH.
  - On grant with `fc`=2: clear `fc`, go to FIRE.
  - Without grant: hold the address and `ld_sel` unchanged.
- FIRE: one cycle.
  - `dp_start`=1, `mem_req`=0.
  - `dp_width` = 24 if `tc`=NT-1, else 36.
  - Go to WAIT.
- WAIT: remain until `dp_done`=1, then go to ADV.
- ADV: one cycle.
  - If `tc`<NT-1: increment `tc`.
  - Otherwise clear `tc` and increment `rc`.
  - If the tile just finished was `tc`=NT-1 and `rc`=OUT_H-1: go to DONE.
  - Otherwise go to FETCH.
- DONE: one cycle with `frame_done`=1, `busy`=1, then go to IDLE.
- `out_row`/`out_col` equal `rc`/`tc`x`TILE_W`.
  - Updated in ADV and valid during FETCH, FIRE and WAIT.
- `dp_done` is ignored outside WAIT.
- `start` is ignored outside IDLE; a `start` in the DONE cycle is also ignored.
- Address arithmetic is unsigned; the maximum `mem_row` is 481 and the maximum `mem_col` is 612, so neither overflows.

## Timing
- Reset: synchronous. On any edge with `rst`=1, go to IDLE, clear all counters and drive every output to 0 from the next cycle. This applies mid-operation: an outstanding request is dropped and no `frame_done` is issued.
- All outputs are registered or decoded from registered state; no input-to-output combinational path except none.
- `start` seen at edge N: `busy`=1 and `mem_req`=1 in cycle N+1.
- Grant at edge k: the next row's address appears in cycle k+1. With `mem_gnt` tied high, the three reads occupy 3 consecutive cycles.
- `dp_start` appears in the cycle after the third grant.
- Per-tile cycles = 3 + gnt stalls + 1 (FIRE) + WAIT cycles (at least 1) + 1 (ADV).
- `dp_done` in the same cycle WAIT is entered is accepted.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs, release. All outputs must read 0 and the FSM must be in IDLE.
- First tile, `mem_gnt`=1, `dp_done` returned 2 cycles after `dp_start`; `start` at cycle 0:
  - Cycles 1-3: `mem_row` 0,1,2, `mem_col`=0, `ld_sel` 0,1,2.
  - Cycle 4: `dp_start`=1, `dp_width`=36.
  - Cycle 7: `mem_col`=36.
- Grant stalls: deassert `mem_gnt` for 4 cycles during `fc`=1. `mem_row`=1 and `ld_sel`=1 must hold steady, and `dp_start` is delayed by exactly 4 cycles.
- Row wrap: at tile 17 of row 0, the request shows `mem_col`=612 and FIRE gives `dp_width`=24. The next request is `mem_row`=1, `mem_col`=0, `out_row`=1.
- Full frame with a `dp_done` responder:
  - Exactly 8640 `dp_start` pulses and 25920 grants.
  - Last request is `mem_row`=481, `mem_col`=612.
  - A single `frame_done` pulse, after which `busy`=0.
  - Spurious `dp_done` during FETCH and `start` while busy cause no change.
- Reset mid-frame at `rc`=5: the next cycle is IDLE with all outputs 0. A new `start` restarts at `mem_row`=0, `mem_col`=0.
